// File: rtl/des_pkg.sv
// Fixed DES key-schedule constants (PC-1, PC-2, shift schedule) and the FSM state
// type shared by the subkey generator and its PC-2 sub-module.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int CD_W     = 56;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_state_e;

  // Entries are 1-based DES bit numbers; DES bit 1 is the MSB of the source word.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // SHIFT[1..16] stored at index 0..15.
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Drops the parity bits and packs C into [55:28], D into [27:0].
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < CD_W; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TAB[6'(i)])];
    end
    return cd;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 compression of the 56-bit {C,D} pair into a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd_i,
  output logic [SUBKEY_W-1:0] subkey_o
);

  // Output bit 47 is PC-2 bit 1; input bit 55 is C bit 1.
  always_comb begin
    subkey_o = '0;
    for (int j = 0; j < SUBKEY_W; j++) begin
      subkey_o[6'(47 - j)] = cd_i[6'(56 - PC2_TAB[6'(j)])];
    end
  end

endmodule

// File: rtl/des_subkey_generator.sv
// Expands a stored DES key into K1..K16 (or K16..K1), one subkey per valid/ready
// handshake, then pulses done for one cycle.
module des_subkey_generator
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY_W-1:0]    key_in,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round,
  output logic                busy,
  output logic                done,
  output des_state_e          state_dbg
);

  // Handshake: subkey/round are offered while subkey_valid is high and stay
  // stable until a cycle with subkey_ready high, at whose clock edge they are
  // consumed and the schedule advances.

  des_state_e        state_q, state_d;
  logic [HALF_W-1:0] c_q, c_d;
  logic [HALF_W-1:0] d_q, d_d;
  logic [3:0]        round_q, round_d;
  logic              dir_q, dir_d;

  logic [1:0]        sh_amt;
  logic [HALF_W-1:0] c_rotl, d_rotl, c_rotr, d_rotr;
  logic [CD_W-1:0]   pc2_in;
  logic              handshake;

  // Decrypt walks backwards, so it rotates right by the shift that produced the
  // current pair and the subkey is taken before that rotation.
  always_comb begin
    sh_amt    = dir_q ? SHIFT_TAB[4'd15 - round_q] : SHIFT_TAB[round_q];
    c_rotl    = rotl28(c_q, sh_amt);
    d_rotl    = rotl28(d_q, sh_amt);
    c_rotr    = rotr28(c_q, sh_amt);
    d_rotr    = rotr28(d_q, sh_amt);
    pc2_in    = dir_q ? {c_q, d_q} : {c_rotl, d_rotl};
    handshake = (state_q == RUN) && subkey_ready;
  end

  des_pc2 u_pc2 (
    .cd_i     (pc2_in),
    .subkey_o (subkey)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          {c_d, d_d} = pc1(key_in);
          dir_d      = decrypt;
          round_d    = 4'd0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (handshake) begin
          c_d     = dir_q ? c_rotr : c_rotl;
          d_d     = dir_q ? d_rotr : d_rotl;
          round_d = round_q + 4'd1;
          if (round_q == 4'd15) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= 4'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dir_q   <= dir_d;
    end
  end

  assign subkey_valid = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign round        = round_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_des_subkey_generator.sv
// Bench for des_subkey_generator: vector table of schedules checked through a
// scoreboard queue filled from an independent key-schedule model.
module tb_des_subkey_generator;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        busy;
  logic        done;
  des_state_e  state_dbg;

  des_subkey_generator dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .decrypt      (decrypt),
    .key_in       (key_in),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int PC1_M [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int PC2_M [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int SH_M [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // K index k (1..16) from the cumulative left shift applied to C0/D0.
  function automatic logic [47:0] model_k(input logic [63:0] key, input int k);
    logic [1:56] cd0;
    logic [1:56] cdk;
    logic [1:48] o;
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += SH_M[i];
    for (int i = 1; i <= 56; i++) cd0[i] = key[6'(64 - PC1_M[i-1])];
    for (int i = 1; i <= 28; i++) begin
      cdk[i]      = cd0[((i - 1 + s) % 28) + 1];
      cdk[28 + i] = cd0[28 + ((i - 1 + s) % 28) + 1];
    end
    for (int j = 1; j <= 48; j++) o[j] = cdk[PC2_M[j-1]];
    return o;
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [51:0] exp_q[$];
  logic [47:0] got_k [16];
  int          n_acc;
  bit          hold_pending;
  logic [47:0] held_sk;
  logic [3:0]  held_rd;

  always @(negedge clk) begin
    if (n_rst) begin
      check("busy_vs_valid", busy, subkey_valid);
      if (subkey_valid) begin
        if (hold_pending) begin
          check("hold_subkey", subkey, held_sk);
          check("hold_round", round, held_rd);
        end
        if (subkey_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_subkey", 64'(exp_q.size() + 1), 64'd0);
          end else begin
            logic [51:0] e;
            e = exp_q.pop_front();
            check("subkey", subkey, e[47:0]);
            check("round", round, e[51:48]);
          end
          if (n_acc < 16) got_k[n_acc] = subkey;
          n_acc++;
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          held_sk      = subkey;
          held_rd      = round;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_sched(input logic [63:0] key, input logic dec);
    for (int r = 0; r < 16; r++) begin
      exp_q.push_back({4'(r), model_k(key, dec ? 16 - r : r + 1)});
    end
    n_acc        = 0;
    hold_pending = 1'b0;
    key_in       = key;
    decrypt      = dec;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic run_to_done(input bit rand_ready, input bit stale,
                             output int cycles, output int valids);
    cycles = 0;
    valids = 0;
    while (done !== 1'b1 && cycles < 400) begin
      subkey_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stale) begin
        key_in  = {$urandom(), $urandom()};
        decrypt = ~decrypt;
        start   = (cycles == 3);
      end
      if (subkey_valid) valids++;
      tick();
      cycles++;
    end
    start = 1'b0;
    check("done_reached", done, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] key;
    logic        dec;
    bit          rand_ready;
    bit          stale;
    bit          chk_ends;
    logic [47:0] first_k;
    logic [47:0] last_k;
  } vec_t;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;
  localparam logic [47:0] K1_A  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  vec_t vecs [6];

  initial begin
    int cycles;
    int valids;
    int budget;

    vecs[0] = '{KEY_A, 1'b0, 1'b0, 1'b0, 1'b1, K1_A, K16_A};
    vecs[1] = '{KEY_A, 1'b1, 1'b0, 1'b0, 1'b1, K16_A, K1_A};
    vecs[2] = '{KEY_A ^ 64'h0101010101010101, 1'b0, 1'b0, 1'b0, 1'b1, K1_A, K16_A};
    vecs[3] = '{KEY_A, 1'b0, 1'b1, 1'b0, 1'b1, K1_A, K16_A};
    vecs[4] = '{KEY_A, 1'b1, 1'b0, 1'b1, 1'b1, K16_A, K1_A};
    vecs[5] = '{KEY_B, 1'b1, 1'b1, 1'b1, 1'b0, 48'h0, 48'h0};

    // Reset/idle: start while in reset does nothing.
    n_rst        = 1'b0;
    start        = 1'b0;
    decrypt      = 1'b0;
    key_in       = KEY_A;
    subkey_ready = 1'b1;
    hold_pending = 1'b0;
    n_acc        = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_subkey", subkey, 48'h0);
    check("rst_valid", subkey_valid, 1'b0);
    check("rst_round", round, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    n_rst = 1'b1;
    repeat (3) tick();
    check("idle_valid", subkey_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_state", state_dbg, IDLE);

    foreach (vecs[v]) begin
      start_sched(vecs[v].key, vecs[v].dec);
      check("first_valid", subkey_valid, 1'b1);
      check("first_round", round, 4'd0);
      check("first_busy", busy, 1'b1);
      run_to_done(vecs[v].rand_ready, vecs[v].stale, cycles, valids);
      if (!vecs[v].rand_ready) begin
        check("cycles_to_done", cycles, 16);
        check("valid_cycles", valids, 16);
      end
      check("accepted_count", n_acc, 16);
      check("queue_empty", exp_q.size(), 0);
      if (vecs[v].chk_ends) begin
        check("first_subkey", got_k[0], vecs[v].first_k);
        check("last_subkey", got_k[15], vecs[v].last_k);
      end
      // A start presented in the DONE cycle must not restart.
      key_in  = KEY_B;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      check("done_single", done, 1'b0);
      check("no_restart_valid", subkey_valid, 1'b0);
      check("no_restart_state", state_dbg, IDLE);
      tick();
      check("idle_after_done", subkey_valid, 1'b0);
    end

    // Reset mid-schedule at round 7, then a fresh schedule with another key.
    subkey_ready = 1'b1;
    start_sched(KEY_A, 1'b0);
    budget = 0;
    while (round !== 4'd7 && budget < 40) begin
      tick();
      budget++;
    end
    check("reached_round7", round, 4'd7);
    n_rst = 1'b0;
    #1;
    check("midrst_subkey", subkey, 48'h0);
    check("midrst_valid", subkey_valid, 1'b0);
    check("midrst_round", round, 4'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    exp_q.delete();
    hold_pending = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    check("post_rst_idle", subkey_valid, 1'b0);
    start_sched(KEY_B, 1'b0);
    check("restart_round", round, 4'd0);
    run_to_done(1'b0, 1'b0, cycles, valids);
    check("restart_cycles", cycles, 16);
    check("restart_accepted", n_acc, 16);
    check("restart_queue_empty", exp_q.size(), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/des_subkey_generator.md
Name: des_subkey_generator

Overview:
- Reads the stored 64-bit DES key and expands it into the sixteen 48-bit round subkeys.
- Delivers subkeys one per accepted handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key register bank and each DES round engine of the 3DES pipeline; one instance per DES stage.

Parameters:
- None. All DES widths and tables are fixed constants in des_pkg.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a schedule; sampled only in IDLE.
- decrypt  input  1  0 = K1..K16, 1 = K16..K1; sampled with start.
- key_in  input  64  stored DES key; bit 63 is DES bit 1; parity bits (DES 8,16,...,64) are ignored.
- subkey  output  48  current subkey; bit 47 is PC-2 output bit 1.
- subkey_valid  output  1  subkey and round are valid.
- subkey_ready  input  1  consumer accepts the subkey this cycle.
- round  output  4  0-based index of the round being delivered (0..15), not the K index.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the 16th subkey is accepted.

Behaviour:
- Reset values: subkey=0, subkey_valid=0, round=0, busy=0, done=0, C=D=0, state=IDLE.
- FSM states and transitions:
  - IDLE: on start, load {C,D} <= PC1(key_in), latch decrypt into dir_q, round <= 0, go to RUN.
  - RUN: subkey_valid=1 and busy=1.
  - On a handshake (subkey_valid & subkey_ready): update C/D and increment round.
  - On the handshake with round==15: go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge T; subkey_valid rises after edge T and round 0 is visible in the cycle following T.
- Throughput: one subkey per cycle while subkey_ready is held high. A 16-subkey schedule plus the done cycle takes 17 cycles after start.
- Shift schedule SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Encrypt, round r (0-based):
  - subkey = PC2(rotl(C,SHIFT[r+1]), rotl(D,SHIFT[r+1])), computed combinationally from the registers.
  - On handshake, C/D <= the rotated values.
- Decrypt, round r:
  - subkey = PC2(C,D) unrotated, so round 0 yields K16 because the total left shift is 28.
  - On handshake, C/D <= rotr(C/D, SHIFT[16-r]).
- Rotations are 28-bit circular, applied to C and D independently.
- Back-pressure: when subkey_ready=0, subkey, round and C/D hold. subkey must stay stable while valid and unaccepted.
- start outside IDLE is ignored. key_in and decrypt changes after start have no effect on the schedule in progress.
- start asserted in the DONE cycle is ignored. The earliest accepted restart is the cycle after done.
- Reset asserted mid-schedule: immediately return to reset values. No partial schedule resumes.
- Outputs in IDLE/DONE: subkey_valid=0. subkey shows the combinational value and is don't-care.

Decomposition:
- des_pkg holds:
  - PC1 table (56 entries)
  - PC2 table (48 entries)
  - SHIFT table
  - state enum {IDLE, RUN, DONE}
  - width constants KEY_W=64, HALF_W=28, SUBKEY_W=48, ROUNDS=16
- Sub-module des_pc2: purely combinational 56→48 permutation, reusable by other schedule blocks.
- PC-1 is applied inline at load.

Test Plan:
- Reset/idle: hold n_rst=0, pulse start → all outputs 0. Release reset with no start → subkey_valid stays 0 and busy=0.
- Encrypt, ready=1: key_in=64'h133457799BBCDFF1, decrypt=0, start → first subkey 48'h1B02EFFC7072 (round=0), last 48'hCB3D8B0E17F5 (round=15). done pulses in the cycle after the last handshake; 16 valid cycles total.
- Decrypt, same key: first subkey 48'hCB3D8B0E17F5, last 48'h1B02EFFC7072. The full sequence equals the encrypt sequence reversed.
- Back-pressure: encrypt run with subkey_ready randomly toggled → subkey and round stable while ready=0. Exactly 16 accepted subkeys, matching the golden model in order.
- Ignored/stale inputs: start pulsed in RUN with a different key_in and decrypt, and key_in changed every cycle → schedule unchanged from the original key and direction. start in the DONE cycle does not restart.
- Reset mid-run: assert n_rst at round=7 → outputs 0 immediately. After release, a new start with key 64'h0123456789ABCDEF produces the correct full schedule from round 0.
